// File: rtl/main_memory_pkg.sv
// main_memory_pkg
//   Shared types and defaults for the main-memory responder.
//   - mem_state_t : responder FSM state encoding
//   - line_align  : clears the within-line bits of a word index
//   - DEF_*       : default parameter values
package main_memory_pkg;

  localparam int unsigned DEF_ADDR_WIDTH    = 32;
  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_LINE_SIZE     = 4;
  localparam int unsigned DEF_MEM_DEPTH     = 4096;
  localparam int unsigned DEF_READ_LATENCY  = 8;
  localparam int unsigned DEF_WRITE_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  // line_size must be a power of two
  function automatic logic [31:0] line_align(input logic [31:0] word_idx,
                                             input int unsigned line_size);
    return word_idx & ~(line_size - 32'd1);
  endfunction

endpackage

// File: rtl/main_memory_storage.sv
// main_memory_storage
//   Single-port synchronous RAM, DEPTH x WIDTH words.
//   Ports:
//     clk     : clock
//     we_i    : write enable, stores wdata_i at addr_i on the rising edge
//     addr_i  : word address (shared by read and write)
//     wdata_i : write data
//     rdata_o : registered read data of the address presented last cycle
module main_memory_storage
  import main_memory_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Main-memory endpoint serving line fills (read) and writebacks (write).
//   One request at a time: accept, wait the programmed latency, transfer
//   LINE_SIZE word beats, then pulse mem_ready for one cycle.
//
//   state | meaning
//   IDLE  | waiting for mem_read / mem_write
//   WAIT  | latency countdown before the first beat
//   BURST | one beat per cycle, mem_beat_idx 0..LINE_SIZE-1
//   DONE  | mem_ready pulse, back to IDLE next cycle
//
//   Ports:
//     clk, reset     : clock, synchronous active-high reset
//     mem_address    : byte address of the request
//     mem_read       : line-fill request
//     mem_write      : writeback request (wins over a simultaneous read)
//     mem_write_data : write beat data, sampled at beat edges
//     mem_read_data  : read beat data, zero outside read beats
//     mem_beat       : beat strobe
//     mem_beat_idx   : word index within the line
//     mem_busy       : transaction in progress
//     mem_ready      : one-cycle completion pulse
module main_memory_responder
  import main_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned LINE_SIZE     = DEF_LINE_SIZE,
  parameter int unsigned MEM_DEPTH     = DEF_MEM_DEPTH,
  parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        mem_address,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [DATA_WIDTH-1:0]        mem_write_data,
  output logic [DATA_WIDTH-1:0]        mem_read_data,
  output logic                         mem_beat,
  output logic [$clog2(LINE_SIZE)-1:0] mem_beat_idx,
  output logic                         mem_busy,
  output logic                         mem_ready
);

  localparam int unsigned MEM_AW  = $clog2(MEM_DEPTH);
  localparam int unsigned IDX_W   = $clog2(LINE_SIZE);
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT) + 1;

  // The counter is loaded with latency-2 so WAIT lasts latency-1 cycles.
  localparam logic [LAT_W-1:0] RD_WAIT_INIT = LAT_W'((READ_LATENCY  > 1) ? READ_LATENCY  - 2 : 0);
  localparam logic [LAT_W-1:0] WR_WAIT_INIT = LAT_W'((WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(LINE_SIZE - 1);

  mem_state_t        state_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [MEM_AW-1:0] base_q;
  logic              is_write_q;
  logic              busy_q;
  logic              beat_q;
  logic              ready_q;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [MEM_AW-1:0]     req_base_d;
  logic [MEM_AW-1:0]     ram_addr_d;
  logic                  ram_we_d;
  logic [IDX_W-1:0]      idx_nxt;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Truncation to MEM_AW makes upper address bits alias.
  assign word_idx   = mem_address >> 2;
  assign req_base_d = MEM_AW'(line_align(32'(word_idx), LINE_SIZE));
  assign idx_nxt    = idx_q + IDX_W'(1);

  // Reads run one cycle ahead of the beat because the RAM output is
  // registered; writes target the current beat's word.
  always_comb begin
    ram_we_d   = 1'b0;
    ram_addr_d = base_q;
    case (state_q)
      IDLE:  ram_addr_d = req_base_d;
      BURST: begin
        if (is_write_q) begin
          ram_we_d   = !reset;
          ram_addr_d = base_q | MEM_AW'(idx_q);
        end else begin
          ram_addr_d = base_q | MEM_AW'(idx_nxt);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      idx_q      <= '0;
      base_q     <= '0;
      is_write_q <= 1'b0;
      busy_q     <= 1'b0;
      beat_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (mem_write || mem_read) begin
            is_write_q <= mem_write;
            base_q     <= req_base_d;
            busy_q     <= 1'b1;
            idx_q      <= '0;
            if ((mem_write && WRITE_LATENCY == 1) || (!mem_write && READ_LATENCY == 1)) begin
              state_q <= BURST;
              beat_q  <= 1'b1;
            end else begin
              state_q   <= WAIT;
              lat_cnt_q <= mem_write ? WR_WAIT_INIT : RD_WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt_q == '0) begin
            state_q <= BURST;
            beat_q  <= 1'b1;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        BURST: begin
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            beat_q  <= 1'b0;
            ready_q <= 1'b1;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_nxt;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  main_memory_storage #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_storage (
    .clk     (clk),
    .we_i    (ram_we_d),
    .addr_i  (ram_addr_d),
    .wdata_i (mem_write_data),
    .rdata_o (ram_rdata)
  );

  assign mem_read_data = (beat_q && !is_write_q) ? ram_rdata : '0;
  assign mem_beat      = beat_q;
  assign mem_beat_idx  = idx_q;
  assign mem_busy      = busy_q;
  assign mem_ready     = ready_q;

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

  localparam int RL    = 8;
  localparam int WL    = 4;
  localparam int LS    = 4;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_address = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_beat;
  logic [1:0]  mem_beat_idx;
  logic        mem_busy;
  logic        mem_ready;

  // Requester line buffer, muxed by the registered beat index.
  logic [31:0] wline [LS];
  assign mem_write_data = wline[mem_beat_idx];

  main_memory_responder dut (
    .clk            (clk),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_beat       (mem_beat),
    .mem_beat_idx   (mem_beat_idx),
    .mem_busy       (mem_busy),
    .mem_ready      (mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  int busy_lo  = -1;
  int busy_hi  = -2;

  // Reference memory: word index -> value, absent means never written (0).
  logic [31:0] model [int];

  typedef struct {
    bit          is_ready;
    int          cyc;
    int          idx;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;
  exp_t exp_q [$];

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, expv);
    end
  endtask

  function automatic int line_base(input logic [31:0] a);
    int w;
    w = int'(a >> 2);
    return ((w / LS) * LS) % DEPTH;
  endfunction

  function automatic logic [31:0] model_rd(input int w);
    return model.exists(w) ? model[w] : 32'h0;
  endfunction

  // Issue one request in the next cycle (cycle 0); optionally pulse an extra
  // read at cycle extra_at. Returns at the ready cycle, so the next call
  // lands on the earliest acceptable cycle.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                       input int extra_at);
    int t0, lat, base;
    @(negedge clk);
    mem_address = addr;
    mem_read    = rd;
    mem_write   = wr;
    t0   = cyc;
    lat  = wr ? WL : RL;
    base = line_base(addr);
    for (int i = 0; i < LS; i++) begin
      exp_q.push_back('{1'b0, t0 + lat + i, i, wr ? 32'h0 : model_rd(base + i), !wr});
    end
    if (wr) begin
      for (int i = 0; i < LS; i++) model[base + i] = wline[i];
    end
    exp_q.push_back('{1'b1, t0 + lat + LS, 0, 32'h0, 1'b0});
    busy_lo = t0 + 1;
    busy_hi = t0 + lat + LS;
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    while (cyc < t0 + lat + LS) begin
      mem_read = (extra_at > 0 && cyc == t0 + extra_at);
      @(negedge clk);
    end
    mem_read = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check(1'b0, e.is_ready ? "missing_ready" : "missing_beat", 32'(cyc), 32'(e.cyc));
      end
      check(mem_busy == (cyc >= busy_lo && cyc <= busy_hi), "busy",
            32'(mem_busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (!mem_beat) check(mem_read_data == 32'h0, "idle_read_data", mem_read_data, 32'h0);
      if (mem_beat) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check(!e.is_ready && e.cyc == cyc, "beat_timing", 32'(cyc), 32'(e.cyc));
          check(32'(mem_beat_idx) == 32'(e.idx), "beat_idx", 32'(mem_beat_idx), 32'(e.idx));
          if (e.chk_data) check(mem_read_data == e.data, "read_data", mem_read_data, e.data);
        end
      end
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check(e.is_ready && e.cyc == cyc, "ready_timing", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check(mem_busy  == 1'b0, {tag, "_busy"},  32'(mem_busy),  32'h0);
    check(mem_beat  == 1'b0, {tag, "_beat"},  32'(mem_beat),  32'h0);
    check(mem_ready == 1'b0, {tag, "_ready"}, 32'(mem_ready), 32'h0);
    check(mem_beat_idx == 2'd0, {tag, "_idx"}, 32'(mem_beat_idx), 32'h0);
    check(mem_read_data == 32'h0, {tag, "_rdata"}, mem_read_data, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0;
    for (int i = 0; i < LS; i++) wline[i] = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // 1. write then read back
    wline[0] = 32'h11111111; wline[1] = 32'h22222222;
    wline[2] = 32'h33333333; wline[3] = 32'h44444444;
    issue(1'b0, 1'b1, 32'h0000_0008, 0);
    issue(1'b1, 1'b0, 32'h0000_0004, 0);

    // 2. unwritten line
    issue(1'b1, 1'b0, 32'h0000_1000, 0);

    // 3. simultaneous read+write: write wins
    for (int i = 0; i < LS; i++) wline[i] = 32'hAAAABBBB;
    issue(1'b1, 1'b1, 32'h0000_000C, 0);
    issue(1'b1, 1'b0, 32'h0000_000C, 0);

    // 4. request while busy is ignored
    issue(1'b1, 1'b0, 32'h0000_0020, 3);

    // 5. reset in cycle 5 of a read
    @(negedge clk);
    mem_address = 32'h0000_0000;
    mem_read    = 1'b1;
    t0 = cyc;
    busy_lo = t0 + 1;
    busy_hi = t0 + 5;
    @(negedge clk);
    mem_read = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    issue(1'b1, 1'b0, 32'h0000_0000, 0);

    // 6. address aliasing
    for (int i = 0; i < LS; i++) wline[i] = $urandom;
    issue(1'b0, 1'b1, 32'h0000_0000, 0);
    issue(1'b1, 1'b0, 32'h0000_4000, 0);

    // Randomized traffic over a few lines and their aliases
    for (int n = 0; n < 24; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = 32'($urandom_range(0, 1)) * 32'h4000 + 32'($urandom_range(0, 7)) * 32'd16
         + 32'($urandom_range(0, 15));
      for (int i = 0; i < LS; i++) wline[i] = $urandom;
      issue(op != 1, op != 0, a, 0);
    end

    repeat (3) @(negedge clk);
    check(exp_q.size() == 0, "queue_drain", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Main-memory model at the bottom of the multi-level cache hierarchy, answering line-fill (read) and writeback (write) requests from the shared L2 cache. It accepts one request at a time, waits a programmable access latency, then transfers a full cache line as LINE_SIZE word beats and signals completion with a one-cycle `mem_ready` pulse. It is synthesizable, and it also serves as the memory endpoint in system testbenches.

## Interface
- ADDR_WIDTH, 32: byte-address width.
- DATA_WIDTH, 32: word and beat width.
- LINE_SIZE, 4: words per cache line. Must be a power of 2.
- MEM_DEPTH, 4096: storage depth in words. Must be a power of 2.
- READ_LATENCY, 8: cycles from accept to first read beat. Must be ≥1.
- WRITE_LATENCY, 4: cycles from accept to first write beat. Must be ≥1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_address  in  ADDR_WIDTH  byte address of the request.
- mem_read  in  1  line-fill request.
- mem_write  in  1  writeback request.
- mem_write_data  in  DATA_WIDTH  write beat data, sampled on edges where `mem_beat`=1.
- mem_read_data  out  DATA_WIDTH  read beat data. Valid only when `mem_beat`=1; 0 otherwise.
- mem_beat  out  1  beat strobe.
- mem_beat_idx  out  $clog2(LINE_SIZE)  index of the current word within the line.
- mem_busy  out  1  transaction in progress.
- mem_ready  out  1  one-cycle completion pulse.

## Operation
- **Address mapping.** Word index = `mem_address >> 2`. The low $clog2(LINE_SIZE) bits of the word index are cleared to line-align the request. The result is taken modulo MEM_DEPTH, so upper address bits alias.
- **FSM states:** IDLE, WAIT, BURST, DONE.
- **IDLE.** If `mem_write` or `mem_read` is high, the block latches the operation and the aligned address. It then moves to WAIT, or directly to BURST when the applicable latency is 1. A one-cycle request pulse is sufficient.
- **Simultaneous request.** If `mem_read` and `mem_write` are both high in IDLE, the write is performed and the read is dropped. The requester must re-issue the read.
- **WAIT.** A latency counter runs for (latency−1) cycles, then the FSM moves to BURST.
- **BURST.** Exactly LINE_SIZE beats, with `mem_beat_idx` counting 0..LINE_SIZE−1.
  - Read: drives word line_base+idx on `mem_read_data`.
  - Write: stores `mem_write_data` into word line_base+idx at the beat edge.
- **DONE.** `mem_ready`=1 for one cycle, then the FSM returns to IDLE.
- **Requests while busy.** `mem_read`/`mem_write` are ignored in WAIT, BURST and DONE. A request still held high in the first IDLE cycle after DONE starts a new transaction.
- **Reset.**
  - All outputs read 0 and the FSM is in IDLE after the reset edge.
  - A reset mid-transaction aborts it. Write beats already stored remain.
  - Storage is not cleared by reset. Its simulation initial value is all zeros.

## Timing
- Cycle 0 is the IDLE cycle in which the request is high; L is the applicable latency.
- `mem_busy`=1 in cycles 1..L+LINE_SIZE.
- `mem_beat`=1 in cycles L..L+LINE_SIZE−1.
- `mem_ready`=1 in cycle L+LINE_SIZE.
- The next request is accepted in cycle L+LINE_SIZE+1 at the earliest.
- All outputs are registered.
- Storage read is synchronous, so read addresses are issued one cycle ahead of the beat.
- Write data must be valid at the beat edge. The requester muxes its line buffer using the registered `mem_beat_idx`.
- The latency counter is $clog2(max latency)+1 bits and the beat counter is $clog2(LINE_SIZE) bits. Neither wraps within a transaction.

## Structure
- Package `main_memory_pkg`:
  - `mem_state_t` enum (IDLE, WAIT, BURST, DONE).
  - Line-alignment helper function.
  - Default parameter constants.
- Sub-module `main_memory_storage`: single-port synchronous RAM, MEM_DEPTH×DATA_WIDTH, with write enable. Instantiated once.

## Test plan
The bench uses the defaults (READ_LATENCY=8, WRITE_LATENCY=4, LINE_SIZE=4).

1. **Write then read back.** Pulse a write at 0x0000_0008 with beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 → `mem_beat` in cycles 4–7 with idx 0–3, `mem_ready` in cycle 8. Then read 0x0000_0004 → four beats 0x11111111..0x44444444 in cycles 8–11 (relative to the read's accept cycle), `mem_ready` in cycle 12.
2. **Unwritten line.** Read 0x0000_1000 before any write to it → four beats of 0x0000_0000; `mem_busy` high in cycles 1–12.
3. **Simultaneous request.** `mem_read` and `mem_write` both high at 0x0000_000C with data 0xAAAABBBB in all four beats → write-length timing (ready in cycle 8). A following read of 0x0000_000C returns 0xAAAABBBB in every beat.
4. **Request while busy.** Read at cycle 0, plus another read pulse at cycle 3 → exactly 4 beats and a single `mem_ready` pulse.
5. **Reset mid-read.** Assert reset in cycle 5 of a read → all outputs 0 and `mem_busy`=0 in cycle 6. A new read issued in cycle 7 completes with normal timing.
6. **Address aliasing.** Write to line 0x0000_0000, then read 0x0000_4000 → identical data (alias modulo MEM_DEPTH=4096 words).
